shift_sequencer: RTL
====================

// Module: shift_sequencer
//
// PURPOSE
//  Multi-cycle controller that sequences shift/rotate operations through a narrow
//  per-cycle shift step instead of a full barrel shifter.
//  Accepts one request (operand, amount, direction, mode) over a valid/ready handshake.
//  Iterates STEP bits per cycle; returns the result over a second valid/ready handshake.
//  Sits between the ALU issue logic and the register writeback path.
//
// PARAMETERS
//  WIDTH  8  operand/result width; must be a power of 2
//  STEP   1  max bit positions shifted per SHIFT cycle; 1..WIDTH
//
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      sequencer can accept a request
//  req_data   in   WIDTH  operand
//  req_amt    in   8      shift amount, unsigned
//  req_dir    in   1      0 = left, 1 = right
//  req_mode   in   1      0 = logical (zero fill), 1 = rotate
//  abort      in   1      synchronous cancel of the in-flight operation
//  busy       out  1      high in SHIFT or DONE
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer takes result
//  rsp_data   out  WIDTH  result
//
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      state=IDLE; rsp_data=0; rsp_valid=0; busy=0; req_ready=1; internal count=0.
//  - Effective amount EFF:
//      rotate:  req_amt mod WIDTH
//      logical: min(req_amt, WIDTH)
//  - States: IDLE, SHIFT, DONE. One operation in flight; no overlap.
//  - IDLE:
//      req_ready=1.
//      On req_valid: latch operand, EFF, dir and mode; go to SHIFT.
//  - SHIFT:
//      req_ready=0.
//      Each cycle: s = min(cnt, STEP); shift/rotate the working register by s; cnt -= s.
//      When cnt after this cycle's update is 0, go to DONE.
//      When EFF=0: one SHIFT cycle, data unchanged.
//  - Per-step operations, s bits:
//      left logical  = d << s
//      right logical = d >> s (zero fill)
//      left rotate   = bits shifted out of the MSB re-enter at the LSB
//      right rotate  = mirror of left rotate
//  - DONE:
//      rsp_valid=1; rsp_data holds the result, stable until the handshake.
//      On rsp_ready: go to IDLE. rsp_valid drops the next cycle.
//      rsp_data keeps its last value in IDLE.
//  - Latency: request accepted at edge k -> rsp_valid=1 from edge k+1+max(1, ceil(EFF/STEP)).
//  - Backpressure:
//      rsp_ready low holds DONE indefinitely.
//      req_valid during SHIFT/DONE is ignored, not latched.
//  - abort:
//      From SHIFT or DONE, go to IDLE on the next edge; rsp_valid=0; result discarded.
//      In IDLE, abort has priority over req_valid: no accept that cycle.
//  - rst_n asserted mid-operation: immediate return to reset values.
//
// CONFIGURATION
//  SHIFT_EARLY_OUT_EN
//    defined:
//      If EFF=0, or logical mode with req_amt >= WIDTH, IDLE goes directly to DONE.
//      Result is the operand (EFF=0) or 0 (logical saturation). Latency 1 cycle.
//    undefined:
//      All requests go through SHIFT.
//      Logical saturation iterates ceil(WIDTH/STEP) cycles; result is still 0.
//
// TESTING
//  1. STEP=1, left logical, data 0x81, amt 3 -> rsp_data 0x08, rsp_valid at k+4.
//  2. STEP=1, right rotate, data 0x81, amt 9 (EFF=1) -> rsp_data 0xC0, rsp_valid at k+2.
//  3. STEP=4, left rotate, data 0x96, amt 6 -> rsp_data 0xA5, rsp_valid at k+3.
//  4. Right logical, data 0xFF, amt 200 -> rsp_data 0x00.
//       EN defined: rsp_valid at k+1.
//       EN undefined, STEP=1: rsp_valid at k+9.
//  5. Hold rsp_ready=0 for 5 cycles in DONE, pulse req_valid with data 0x55 ->
//       rsp_data stable, req_ready=0, 0x55 never accepted.
//  6. abort in 2nd SHIFT cycle -> IDLE next edge, rsp_valid never rises.
//     rst_n pulse mid-SHIFT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for shift_sequencer.
//   master : requester side (drives req_*, abort, rsp_ready)
//   slave  : sequencer side (drives req_ready, busy, rsp_valid, rsp_data)
// Signals:
//   req_valid/req_ready  request handshake
//   req_data             operand, WIDTH bits
//   req_amt              shift amount, 8 bits unsigned
//   req_dir              0 = left, 1 = right
//   req_mode             0 = logical (zero fill), 1 = rotate
//   abort                synchronous cancel of the in-flight operation
//   busy                 sequencer is in SHIFT or DONE
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             result, WIDTH bits
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [7:0]       req_amt;
    logic             req_dir;
    logic             req_mode;
    logic             abort;
    logic             busy;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_data, req_amt, req_dir, req_mode, abort, rsp_ready,
        input  req_ready, busy, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, req_mode, abort, rsp_ready,
        output req_ready, busy, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: moves the operand at most STEP bit
// positions per cycle instead of using a full barrel shifter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_sequencer_if.slave (request and response handshakes, abort, busy)
// Parameters:
//   WIDTH  operand/result width, power of 2
//   STEP   max bit positions per SHIFT cycle, 1..WIDTH
// Optional feature macro: SHIFT_EARLY_OUT_EN
//   When defined, zero-amount and saturated logical requests skip SHIFT.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_rsp_data;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_mode;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             r_req_ready;

    logic [CW-1:0]    w_eff;
    logic [CW-1:0]    w_step;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        // Rotate wraps the amount; logical saturates at WIDTH (all bits gone).
        if (bus.req_mode) begin
            w_eff = CW'(32'(bus.req_amt) % WIDTH);
        end else if (32'(bus.req_amt) >= WIDTH) begin
            w_eff = CW'(WIDTH);
        end else begin
            w_eff = CW'(bus.req_amt);
        end

        w_step     = (r_cnt > CW'(STEP)) ? CW'(STEP) : r_cnt;
        w_cnt_next = r_cnt - w_step;

        // A shift by WIDTH yields zero, so rotate by 0 needs no special case.
        case ({r_mode, r_dir})
            2'b00:   w_shifted = r_work << w_step;
            2'b01:   w_shifted = r_work >> w_step;
            2'b10:   w_shifted = (r_work << w_step) | (r_work >> (CW'(WIDTH) - w_step));
            default: w_shifted = (r_work >> w_step) | (r_work << (CW'(WIDTH) - w_step));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_rsp_data  <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_mode      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.abort && bus.req_valid) begin
                        r_work      <= bus.req_data;
                        r_cnt       <= w_eff;
                        r_dir       <= bus.req_dir;
                        r_mode      <= bus.req_mode;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
`ifdef SHIFT_EARLY_OUT_EN
                        if (w_eff == '0 || (!bus.req_mode && 32'(bus.req_amt) >= WIDTH)) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                            if (w_eff != '0) begin
                                r_work <= '0;
                            end
                        end else begin
                            r_state <= SHIFT;
                        end
`else
                        r_state <= SHIFT;
`endif
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_work <= w_shifted;
                        r_cnt  <= w_cnt_next;
                        if (w_cnt_next == '0) begin
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
                    // First DONE cycle registers the result onto the response
                    // port; the handshake is only honoured once rsp_valid is up.
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_work;
                    end else if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule
